sync_patch_packer: RTL and testbench

//  Consumes the per-patch synchronized, companded camera bytes from the patch-sync stage.

---
 rtl/sync_patch_packer.sv | 189 ++++++++++++++++++
 tb/tb_sync_patch_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_patch_packer.sv
`default_nettype none
// sync_patch_packer: frames synchronized camera records into HDR/DATA/TRL words
// and queues them in a first-word-fall-through FIFO toward the crossbar. Rev 1.0
module sync_patch_packer #(
  parameter int N_CAM         = 3,
  parameter int COMPRESS_SIZE = 8,
  parameter int N_PATCH       = 4096,
  parameter int XB_SIZE       = 32,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             in_valid,
  input  logic [$clog2(N_PATCH)-1:0]       in_patch,
  input  logic [N_CAM*COMPRESS_SIZE-1:0]   in_data,
  input  logic                             in_sof,
  input  logic                             in_eof,
  output logic                             xb_valid,
  output logic [XB_SIZE-1:0]               xb_data,
  input  logic                             xb_ready,
  output logic                             ready,
  output logic                             overflow,
  output logic                             seq_err
);

  localparam int PW   = $clog2(N_PATCH);
  localparam int DW   = N_CAM * COMPRESS_SIZE;
  localparam int SEQW = XB_SIZE - 2 - DW;
  localparam int CW   = XB_SIZE - 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_HDR  = 2'd1;
  localparam logic [1:0] K_DATA = 2'd2;
  localparam logic [1:0] K_TRL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     frame_cnt_q;
  logic [CW-1:0]     rec_cnt_q;
  logic [PW-1:0]     exp_patch_q;
  logic              overflow_q;
  logic              seq_err_q;

  logic [XB_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;

  logic               multi;
  logic               in_order;
  logic [CW-1:0]      frame_inc;
  logic [CW-1:0]      rec_inc;
  logic [SEQW-1:0]    seq_field;
  logic [XB_SIZE-1:0] hdr_word;
  logic [XB_SIZE-1:0] data_word;
  logic [XB_SIZE-1:0] trl_word;
  logic [XB_SIZE-1:0] wr_word;
  logic [1:0]         wr_kind;
  logic               wr_req;
  logic               wr_ok;
  logic               pop;
  logic               full;
  logic               seq_viol;

  generate
    if (SEQW <= PW) begin : g_seq_trunc
      assign seq_field = in_patch[SEQW-1:0];
    end else begin : g_seq_ext
      assign seq_field = SEQW'(in_patch);
    end
  endgenerate

  assign multi     = (in_valid & in_sof) | (in_valid & in_eof) | (in_sof & in_eof);
  assign in_order  = (in_patch == exp_patch_q);
  assign frame_inc = frame_cnt_q + CW'(1);
  assign rec_inc   = (&rec_cnt_q) ? rec_cnt_q : rec_cnt_q + CW'(1);

  assign hdr_word  = {2'b01, frame_inc};
  assign data_word = {(in_order ? 2'b00 : 2'b11), seq_field, in_data};
  assign trl_word  = {2'b10, rec_cnt_q};

  // Conflicting strobes are a protocol fault: nothing is written that cycle.
  always_comb begin
    wr_kind = K_NONE;
    if (!multi) begin
      case (state_q)
        S_FRAME: begin
          if (in_sof)        wr_kind = K_HDR;
          else if (in_valid) wr_kind = K_DATA;
          else if (in_eof)   wr_kind = K_TRL;
        end
        default: begin
          if (in_sof)        wr_kind = K_HDR;
        end
      endcase
    end
  end

  always_comb begin
    case (wr_kind)
      K_HDR:   wr_word = hdr_word;
      K_DATA:  wr_word = data_word;
      K_TRL:   wr_word = trl_word;
      default: wr_word = '0;
    endcase
  end

  assign seq_viol = multi
                  | (!multi && (state_q == S_IDLE)  && (in_valid || in_eof))
                  | (!multi && (state_q == S_FRAME) && in_sof)
                  | (!multi && (state_q == S_FRAME) && !in_sof && in_valid && !in_order);

  assign full   = (count_q == DEPTH_C);
  assign pop    = xb_valid && xb_ready;
  assign wr_req = (wr_kind != K_NONE);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_ok  = wr_req && (!full || pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      rec_cnt_q   <= '0;
      exp_patch_q <= '0;
      overflow_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      if (seq_viol) seq_err_q <= 1'b1;
      if (wr_req && !wr_ok) begin
        overflow_q <= 1'b1;
        state_q    <= S_ERROR;
      end else if (wr_ok) begin
        case (wr_kind)
          K_HDR: begin
            frame_cnt_q <= frame_inc;
            rec_cnt_q   <= '0;
            exp_patch_q <= '0;
            state_q     <= S_FRAME;
          end
          K_DATA: begin
            rec_cnt_q   <= rec_inc;
            exp_patch_q <= in_patch + PW'(1);
          end
          K_TRL: begin
            state_q     <= S_IDLE;
          end
          default: begin
            state_q     <= state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign xb_valid = (count_q != '0);
  assign xb_data  = xb_valid ? mem_q[rd_ptr_q] : '0;
  assign ready    = (state_q != S_ERROR);
  assign overflow = overflow_q;
  assign seq_err  = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_patch_packer.sv
`default_nettype none
// tb_sync_patch_packer: directed stimulus with a queue-based reference model
// compared every cycle, plus literal checks on the captured output stream.
module tb_sync_patch_packer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_patch = '0;
  logic [23:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        xb_ready = 1'b0;
  logic        xb_valid;
  logic [31:0] xb_data;
  logic        ready;
  logic        overflow;
  logic        seq_err;

  int checks = 0;
  int errors = 0;

  sync_patch_packer dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .in_valid (in_valid),
    .in_patch (in_patch),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_eof   (in_eof),
    .xb_valid (xb_valid),
    .xb_data  (xb_data),
    .xb_ready (xb_ready),
    .ready    (ready),
    .overflow (overflow),
    .seq_err  (seq_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: queue of words the consumer must see, plus frame bookkeeping.
  logic [31:0] mq[$];
  int          m_mode  = 0;   // 0 idle, 1 in frame, 2 error
  int unsigned m_frame = 0;
  int unsigned m_rec   = 0;
  int unsigned m_exp   = 0;
  bit          m_ovf   = 0;
  bit          m_seq   = 0;

  task automatic model_step();
    int          n;
    bit          popped;
    bit          want;
    int          kind;   // 1 hdr, 2 data, 3 trl
    logic [31:0] w;
    n      = int'(in_valid) + int'(in_sof) + int'(in_eof);
    popped = (mq.size() > 0) && xb_ready;
    want   = 0;
    kind   = 0;
    w      = '0;
    if (n > 1) m_seq = 1;
    else if (m_mode == 1) begin
      if (in_sof) begin kind = 1; m_seq = 1; end
      else if (in_valid) begin
        kind = 2;
        if (int'(in_patch) != m_exp) m_seq = 1;
      end
      else if (in_eof) kind = 3;
    end else begin
      if (in_sof) kind = 1;
      else if (m_mode == 0 && (in_valid || in_eof)) m_seq = 1;
    end
    want = (kind != 0);
    case (kind)
      1: w = {2'b01, 30'((m_frame + 1) % (1 << 30))};
      2: w = {((int'(in_patch) == m_exp) ? 2'b00 : 2'b11), 6'(in_patch % 64), in_data};
      3: w = {2'b10, 30'(m_rec)};
      default: w = '0;
    endcase
    if (popped) void'(mq.pop_front());
    if (want) begin
      if (mq.size() < 16) begin
        mq.push_back(w);
        case (kind)
          1: begin m_frame = (m_frame + 1) % (1 << 30); m_rec = 0; m_exp = 0; m_mode = 1; end
          2: begin
               if (m_rec < (1 << 30) - 1) m_rec = m_rec + 1;
               m_exp = (int'(in_patch) + 1) % 4096;
             end
          default: m_mode = 0;
        endcase
      end else begin
        m_ovf  = 1;
        m_mode = 2;
      end
    end
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mq.delete();
      m_mode = 0; m_frame = 0; m_rec = 0; m_exp = 0; m_ovf = 0; m_seq = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge CLK) begin
    chk("xb_valid", {31'd0, xb_valid}, {31'd0, mq.size() != 0});
    chk("xb_data", xb_data, (mq.size() != 0) ? mq[0] : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("seq_err", {31'd0, seq_err}, {31'd0, m_seq});
    chk("ready", {31'd0, ready}, {31'd0, m_mode != 2});
  end

  logic [31:0] got[$];

  // Called just after a falling edge: apply inputs, note any word the next edge consumes.
  task automatic step(input bit v, input int p, input logic [23:0] d,
                      input bit s, input bit e, input bit r);
    in_valid = v; in_patch = 12'(p); in_data = d; in_sof = s; in_eof = e; xb_ready = r;
    #1;
    if (xb_valid && xb_ready) got.push_back(xb_data);
    @(negedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!xb_valid) break;
      step(0, 0, 24'd0, 0, 0, 1);
    end
    chk("drain_empty", {31'd0, xb_valid}, 32'd0);
    step(0, 0, 24'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, xb_valid}, 32'd0);
    chk("rst_async_data", xb_data, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_valid", {31'd0, xb_valid}, 32'd0);
    chk("reset_data", xb_data, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_seq", {31'd0, seq_err}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    RESET_N = 1'b1;

    // Basic in-order frame
    step(0, 0, 24'd0, 1, 0, 1);
    step(1, 0, 24'h112233, 0, 0, 1);
    step(1, 1, 24'h445566, 0, 0, 1);
    step(1, 2, 24'h778899, 0, 0, 1);
    step(0, 0, 24'd0, 0, 1, 1);
    drain();
    chk("t1_size", got.size(), 5);
    chk("t1_hdr", got[0], 32'h40000001);
    chk("t1_d0", got[1], 32'h00112233);
    chk("t1_d1", got[2], 32'h01445566);
    chk("t1_d2", got[3], 32'h02778899);
    chk("t1_trl", got[4], 32'h80000003);

    // Out-of-order patch, then resynchronised expectation
    got.delete();
    step(0, 0, 24'd0, 1, 0, 1);
    step(1, 0, 24'h0000A0, 0, 0, 1);
    step(1, 1, 24'h0000A1, 0, 0, 1);
    step(1, 3, 24'h0000A3, 0, 0, 1);
    step(1, 4, 24'h0000A4, 0, 0, 1);
    step(0, 0, 24'd0, 0, 1, 1);
    drain();
    chk("t2_hdr", got[0], 32'h40000002);
    chk("t2_ooo", got[3], 32'hC30000A3);
    chk("t2_next", got[4], 32'h040000A4);
    chk("t2_trl", got[5], 32'h80000004);
    chk("t2_seq", {31'd0, seq_err}, 32'd1);

    // Overflow into ERROR, drain, recover
    do_reset();
    step(0, 0, 24'd0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, i, 24'h000100 + 24'(i), 0, 0, 0);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_ready", {31'd0, ready}, 32'd0);
    drain();
    chk("t3_kept", got.size(), 16);
    chk("t3_last", got[15], 32'h0E00010E);
    got.delete();
    step(0, 0, 24'd0, 1, 0, 1);
    step(0, 0, 24'd0, 0, 1, 1);
    drain();
    chk("t3_hdr", got[0], 32'h40000002);
    chk("t3_trl", got[1], 32'h80000000);
    chk("t3_ready2", {31'd0, ready}, 32'd1);

    // Full FIFO with simultaneous write and pop
    do_reset();
    step(0, 0, 24'd0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, i, 24'h000100 + 24'(i), 0, 0, 0);
    chk("t4_full_ovf", {31'd0, overflow}, 32'd0);
    step(1, 15, 24'h00010F, 0, 0, 1);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    got.delete();
    drain();
    chk("t4_count", got.size(), 16);
    chk("t4_first", got[0], 32'h00000100);
    chk("t4_last", got[15], 32'h0F00010F);

    // Conflicting strobes inside a frame
    do_reset();
    step(0, 0, 24'd0, 1, 0, 1);
    step(1, 0, 24'h123456, 0, 1, 1);
    chk("t5_seq", {31'd0, seq_err}, 32'd1);
    chk("t5_ready", {31'd0, ready}, 32'd1);
    step(0, 0, 24'd0, 0, 1, 1);
    drain();
    chk("t5_size", got.size(), 2);
    chk("t5_trl", got[1], 32'h80000000);

    // Reset mid-frame with queued words
    do_reset();
    step(0, 0, 24'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, i, 24'h000200 + 24'(i), 0, 0, 0);
    chk("t6_queued", {31'd0, xb_valid}, 32'd1);
    do_reset();
    step(0, 0, 24'd0, 1, 0, 1);
    drain();
    chk("t6_hdr", got[0], 32'h40000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
